// File: rtl/fft_power_peak_pkg.sv
// Shared constants, state encoding and peak record for the NLP power-spectrum/peak stage.
package fft_power_peak_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned Q      = 16;
  localparam int unsigned NBINS  = 512;
  localparam int unsigned BIN_LO = 16;
  localparam int unsigned BIN_HI = 128;
  localparam int unsigned AW     = 10;

  localparam logic [N-1:0] SAT_MAX = 32'h7FFF_FFFF;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_SET_ADDR  = 4'd2,
    S_WAIT1     = 4'd3,
    S_WAIT2     = 4'd4,
    S_LATCH     = 4'd5,
    S_SQUARE    = 4'd6,
    S_SUM_WRITE = 4'd7,
    S_NEXT      = 4'd8,
    S_DONE      = 4'd9
  } state_e;

  typedef struct packed {
    logic [N-1:0]  val;
    logic [AW-1:0] bin;
  } peak_t;

endpackage

// File: rtl/fft_power_peak_if.sv
// DFT RAM read side, Fw RAM write side and start/done handshake of fft_power_peak.
interface fft_power_peak_if;
  import fft_power_peak_pkg::*;

  logic          startmag;
  logic [AW-1:0] addr_in_real;
  logic [AW-1:0] addr_in_imag;
  logic [N-1:0]  in_real_data;
  logic [N-1:0]  in_imag_data;
  logic [AW-1:0] addr_out_fw;
  logic [N-1:0]  write_fw;
  logic          we_fw;
  logic [N-1:0]  gmax;
  logic [AW-1:0] gmax_bin;
  logic          donemag;

  modport master (
    output startmag, in_real_data, in_imag_data,
    input  addr_in_real, addr_in_imag, addr_out_fw, write_fw, we_fw,
           gmax, gmax_bin, donemag
  );

  modport slave (
    input  startmag, in_real_data, in_imag_data,
    output addr_in_real, addr_in_imag, addr_out_fw, write_fw, we_fw,
           gmax, gmax_bin, donemag
  );

endinterface

// File: rtl/fft_power_peak_qsquare_sat.sv
// Combinational square of a sign-magnitude Q15.16 value, shifted back to Q15.16 and saturated.
module qsquare_sat
  import fft_power_peak_pkg::*;
(
  input  logic [N-1:0] x_i,
  output logic [N-1:0] sq_c
);

  localparam int unsigned PW = 2 * (N - 1);

  logic [N-2:0] mag;
  logic [PW-1:0] prod;
  logic [PW-1:0] shifted;
  logic          unused_sign;

  // The square is always non-negative, so the sign bit plays no part.
  assign unused_sign = x_i[N-1];
  assign mag         = x_i[N-2:0];
  assign prod        = PW'(mag) * PW'(mag);
  assign shifted     = prod >> Q;
  assign sq_c        = (shifted > PW'(SAT_MAX)) ? SAT_MAX : {1'b0, shifted[N-2:0]};

endmodule

// File: rtl/fft_power_peak.sv
// Computes Fw[k] = re^2 + im^2 for every DFT bin, writes it out and tracks the in-range peak.
module fft_power_peak
  import fft_power_peak_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fft_power_peak_if.slave bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] addr_rd_q, addr_rd_d;
  logic [N-1:0]  re_q, re_d;
  logic [N-1:0]  im_q, im_d;
  logic [N-1:0]  sq_re_q, sq_re_d;
  logic [N-1:0]  sq_im_q, sq_im_d;
  logic [AW-1:0] fw_addr_q, fw_addr_d;
  logic [N-1:0]  fw_data_q, fw_data_d;
  logic          we_q, we_d;
  peak_t         peak_q, peak_d;
  logic          done_q, done_d;

  logic [N-1:0]  sq_re_c;
  logic [N-1:0]  sq_im_c;
  logic [N-1:0]  sum_c;
  logic [N-1:0]  fw_c;
  logic          in_range_c;

  qsquare_sat u_sq_re (.x_i(re_q), .sq_c(sq_re_c));
  qsquare_sat u_sq_im (.x_i(im_q), .sq_c(sq_im_c));

  // Both squares have a clear sign bit, so bit N-1 of the sum flags overflow past SAT_MAX.
  assign sum_c      = sq_re_q + sq_im_q;
  assign fw_c       = sum_c[N-1] ? SAT_MAX : sum_c;
  assign in_range_c = (k_q >= AW'(BIN_LO)) && (k_q <= AW'(BIN_HI));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      addr_rd_q <= '0;
      re_q      <= '0;
      im_q      <= '0;
      sq_re_q   <= '0;
      sq_im_q   <= '0;
      fw_addr_q <= '0;
      fw_data_q <= '0;
      we_q      <= 1'b0;
      peak_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_rd_q <= addr_rd_d;
      re_q      <= re_d;
      im_q      <= im_d;
      sq_re_q   <= sq_re_d;
      sq_im_q   <= sq_im_d;
      fw_addr_q <= fw_addr_d;
      fw_data_q <= fw_data_d;
      we_q      <= we_d;
      peak_q    <= peak_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_rd_d = addr_rd_q;
    re_d      = re_q;
    im_d      = im_q;
    sq_re_d   = sq_re_q;
    sq_im_d   = sq_im_q;
    fw_addr_d = fw_addr_q;
    fw_data_d = fw_data_q;
    we_d      = we_q;
    peak_d    = peak_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.startmag) state_d = S_INIT;
      end
      S_INIT: begin
        k_d        = '0;
        peak_d.val = '0;
        peak_d.bin = AW'(BIN_LO);
        we_d       = 1'b0;
        state_d    = S_SET_ADDR;
      end
      S_SET_ADDR: begin
        addr_rd_d = k_q;
        state_d   = S_WAIT1;
      end
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: state_d = S_LATCH;
      S_LATCH: begin
        re_d    = bus.in_real_data;
        im_d    = bus.in_imag_data;
        state_d = S_SQUARE;
      end
      S_SQUARE: begin
        sq_re_d = sq_re_c;
        sq_im_d = sq_im_c;
        state_d = S_SUM_WRITE;
      end
      S_SUM_WRITE: begin
        fw_data_d = fw_c;
        fw_addr_d = k_q;
        we_d      = 1'b1;
        // Strict compare keeps the lower bin on ties.
        if (in_range_c && (fw_c[N-2:0] > peak_q.val[N-2:0])) begin
          peak_d.val = fw_c;
          peak_d.bin = k_q;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        we_d = 1'b0;
        if (k_q == AW'(NBINS - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d     = k_q + AW'(1);
          state_d = S_SET_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.addr_in_real = addr_rd_q;
  assign bus.addr_in_imag = addr_rd_q;
  assign bus.addr_out_fw  = fw_addr_q;
  assign bus.write_fw     = fw_data_q;
  assign bus.we_fw        = we_q;
  assign bus.gmax         = peak_q.val;
  assign bus.gmax_bin     = peak_q.bin;
  assign bus.donemag      = done_q;

endmodule

// File: tb/tb_fft_power_peak.sv
// Directed bench for fft_power_peak with a 2-cycle-latency DFT RAM model and Fw capture.
module tb_fft_power_peak;

  logic clk;
  logic rst;

  fft_power_peak_if bus ();

  fft_power_peak dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_re [0:1023];
  logic [31:0] mem_im [0:1023];
  logic [31:0] fw_got [0:1023];
  logic [31:0] p1_re, p1_im, rd_re, rd_im;

  // Two-stage read pipeline: data at cycle t reflects the address of cycle t-2.
  always @(posedge clk) begin
    p1_re <= mem_re[bus.addr_in_real];
    p1_im <= mem_im[bus.addr_in_imag];
    rd_re <= p1_re;
    rd_im <= p1_im;
  end

  assign bus.in_real_data = rd_re;
  assign bus.in_imag_data = rd_im;

  int tests = 0;
  int fails = 0;
  int cyc, wcount, order_err, done_cnt, done_cyc, done_cyc1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem_re[i] = 32'h0;
      mem_im[i] = 32'h0;
      fw_got[i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.we_fw === 1'b1) begin
      if (bus.addr_out_fw !== 10'(wcount % 512)) order_err++;
      fw_got[bus.addr_out_fw] = bus.write_fw;
      wcount++;
    end
    if (bus.donemag === 1'b1) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc1 = cyc;
      done_cyc = cyc;
    end
  endtask

  task automatic start(input bit hold);
    @(negedge clk);
    bus.startmag = 1'b1;
    cyc = 0; wcount = 0; order_err = 0; done_cnt = 0; done_cyc = -1; done_cyc1 = -1;
    @(posedge clk);
    #1;
    if (!hold) bus.startmag = 1'b0;
  endtask

  task automatic run_to_done(input int ndone, input int budget);
    while (done_cnt < ndone && cyc < budget) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " addr_in_real"}, 32'(bus.addr_in_real), 32'h0);
    check({tag, " addr_in_imag"}, 32'(bus.addr_in_imag), 32'h0);
    check({tag, " addr_out_fw"},  32'(bus.addr_out_fw),  32'h0);
    check({tag, " write_fw"},     bus.write_fw,          32'h0);
    check({tag, " we_fw"},        32'(bus.we_fw),        32'h0);
    check({tag, " gmax"},         bus.gmax,              32'h0);
    check({tag, " gmax_bin"},     32'(bus.gmax_bin),     32'h0);
    check({tag, " donemag"},      32'(bus.donemag),      32'h0);
  endtask

  task automatic full_run(input string tag, input logic [31:0] exp_gmax, input logic [31:0] exp_bin);
    start(1'b0);
    run_to_done(1, 3700);
    check({tag, " donemag count"}, 32'(done_cnt), 32'd1);
    check({tag, " done cycle"},    32'(done_cyc), 32'd3586);
    check({tag, " write count"},   32'(wcount),   32'd512);
    check({tag, " write order"},   32'(order_err), 32'd0);
    check({tag, " gmax"},          bus.gmax,      exp_gmax);
    check({tag, " gmax_bin"},      32'(bus.gmax_bin), exp_bin);
    tick();
    check({tag, " donemag pulse"}, 32'(bus.donemag), 32'd0);
    check({tag, " gmax hold"},     bus.gmax,      exp_gmax);
  endtask

  initial begin
    int nz;
    clk = 1'b0;
    rst = 1'b0;
    bus.startmag = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    // All zeros
    clear_mem();
    full_run("zeros", 32'h0, 32'd16);
    nz = 0;
    for (int i = 0; i < 512; i++) if (fw_got[i] !== 32'h0) nz++;
    check("zeros nonzero bins", 32'(nz), 32'd0);

    // Single bin with negative imaginary part
    clear_mem();
    mem_re[40] = 32'h0001_0000;
    mem_im[40] = 32'h8002_0000;
    full_run("single", 32'h0005_0000, 32'd40);
    check("single fw[40]", fw_got[40], 32'h0005_0000);
    check("single fw[39]", fw_got[39], 32'h0);

    // Larger peak outside the search range
    clear_mem();
    mem_re[200] = 32'h000A_0000;
    mem_re[50]  = 32'h0001_0000;
    full_run("outside", 32'h0001_0000, 32'd50);
    check("outside fw[200]", fw_got[200], 32'h0064_0000);

    // Range edges: 15 and 129 excluded, 128 included
    clear_mem();
    mem_re[15]  = 32'h0003_0000;
    mem_re[128] = 32'h0002_0000;
    mem_re[129] = 32'h0005_0000;
    full_run("edges", 32'h0004_0000, 32'd128);
    check("edges fw[15]",  fw_got[15],  32'h0009_0000);
    check("edges fw[129]", fw_got[129], 32'h0019_0000);

    // Ties keep the lower bin
    clear_mem();
    mem_re[30] = 32'h0002_0000;
    mem_re[90] = 32'h0002_0000;
    full_run("ties", 32'h0004_0000, 32'd30);

    // Saturation
    clear_mem();
    mem_re[20] = 32'h7FFF_0000;
    mem_im[20] = 32'h0001_0000;
    full_run("sat", 32'h7FFF_FFFF, 32'd20);
    check("sat fw[20]", fw_got[20], 32'h7FFF_FFFF);

    // startmag held high: back-to-back runs, each started from IDLE
    clear_mem();
    start(1'b1);
    run_to_done(2, 7400);
    bus.startmag = 1'b0;
    check("hold donemag count", 32'(done_cnt),  32'd2);
    check("hold first done",    32'(done_cyc1), 32'd3586);
    check("hold second done",   32'(done_cyc),  32'd7173);
    check("hold write count",   32'(wcount),    32'd1024);
    check("hold write order",   32'(order_err), 32'd0);
    repeat (30) tick();
    check("hold no third run",  32'(wcount),    32'd1024);

    // Reset during bin 100
    clear_mem();
    mem_re[20] = 32'h7FFF_0000;
    start(1'b0);
    while (cyc < 704) tick();
    check("midrst gmax before", bus.gmax, 32'h7FFF_FFFF);
    rst = 1'b0;
    done_cnt = 0;
    tick();
    check_reset("midrst");
    rst = 1'b1;
    wcount = 0;
    repeat (3700) tick();
    check("midrst no donemag", 32'(done_cnt), 32'd0);
    check("midrst no writes",  32'(wcount),   32'd0);

    // Fresh start after reset
    clear_mem();
    mem_re[40] = 32'h0001_0000;
    mem_im[40] = 32'h8002_0000;
    full_run("fresh", 32'h0005_0000, 32'd40);
    check("fresh fw[40]", fw_got[40], 32'h0005_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_power_peak.md
# fft_power_peak

Power-spectrum and peak-search stage directly downstream of the 512-point DFT in the NLP pitch estimator. After `donefft`, it reads the DFT real/imag output RAMs and computes Fw[k] = re² + im² for every bin. It writes Fw to the Fw RAM and, in the same pass, finds the largest Fw and its bin within the pitch search range. All arithmetic uses the codebase's 32-bit sign-magnitude Q15.16 format.

## Interface
- N, 32, data width (sign bit + 15 integer + 16 fraction)
- Q, 16, fraction bits
- NBINS, 512, bins processed (0..NBINS-1)
- BIN_LO, 16, first bin of the peak search, inclusive (512·5/160)
- BIN_HI, 128, last bin of the peak search, inclusive (512·5/20)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (sampled on posedge clk only)
- startmag  in  1  start request, level or pulse
- addr_in_real  out  10  DFT real RAM read address
- addr_in_imag  out  10  DFT imag RAM read address
- in_real_data  in  N  DFT real RAM read data, valid 2 cycles after address
- in_imag_data  in  N  DFT imag RAM read data, valid 2 cycles after address
- addr_out_fw  out  10  Fw RAM write address
- write_fw  out  N  Fw write data
- we_fw  out  1  Fw RAM write enable, one cycle per bin
- gmax  out  N  peak power in [BIN_LO, BIN_HI]
- gmax_bin  out  10  bin index of gmax
- donemag  out  1  one-cycle completion pulse

## Operation
- **Reset values** (rst=0 at posedge): STATE=IDLE; all addresses 0; write_fw 0; we_fw 0; gmax 0; gmax_bin 0; donemag 0.
- **States:**
  - IDLE: go to INIT when startmag=1.
  - INIT: k←0, gmax←0, gmax_bin←BIN_LO.
  - SET_ADDR: addr_in_real/imag←k.
  - WAIT1, WAIT2: cover RAM read latency.
  - LATCH: register in_real_data and in_imag_data.
  - SQUARE: register sq_re and sq_im.
  - SUM_WRITE: write_fw←sat(sq_re+sq_im), addr_out_fw←k, we_fw←1. Peak update (see below).
  - NEXT: we_fw←0. If k=NBINS-1 go to DONE, else k←k+1 and go to SET_ADDR.
  - DONE: donemag←1 for one cycle, then IDLE. donemag is 0 in every other state.
- **Peak update:** in SUM_WRITE, if BIN_LO ≤ k ≤ BIN_HI and the new Fw > gmax (strict, unsigned on bits [N-2:0]), then gmax←Fw and gmax_bin←k. Ties keep the lower bin.
- **Square:** use the magnitude m = x[N-2:0] and ignore the sign. Form the 62-bit product m·m, shift right by Q with truncation. If the result is above 2^31−1, saturate to 32'h7FFF_FFFF. Output sign bit is 0.
- **Sum:** unsigned add of the two 31-bit magnitudes, with the same saturation to 32'h7FFF_FFFF. Fw is never negative.
- startmag is ignored outside IDLE.
- gmax and gmax_bin hold after DONE until the next INIT.
- **Reset mid-operation:** the block returns to IDLE with reset values on the next edge. Fw RAM contents are partial and undefined, and no donemag is issued.
- An unused state encoding goes to IDLE.

## Timing
- 7 cycles per bin: SET_ADDR, WAIT1, WAIT2, LATCH, SQUARE, SUM_WRITE, NEXT.
- If IDLE samples startmag=1 at edge 0, INIT runs in cycle 1 and bin k occupies cycles 2+7k … 8+7k.
- DONE (donemag=1) is in cycle 2+7·NBINS = 3586 for NBINS=512.
- we_fw is high exactly NBINS cycles per run, with addresses 0..NBINS-1 in ascending order.
- Read addresses are stable from SET_ADDR through LATCH.
- The DFT RAMs must not be written while this block is busy. The upstream FSM guarantees this by asserting startmag only after donefft.

## Structure
- **Shared package:** N, Q, NBINS, BIN_LO, BIN_HI, SAT_MAX=32'h7FFF_FFFF, and the state encoding.
- **Sub-module:** `qsquare_sat` (combinational sign-magnitude square with shift and saturate), instantiated twice. The saturating add stays inline.
- **Top:** FSM plus datapath registers only, about 200 lines.

## Test plan
- **All zeros:** all RAM inputs 0 → 512 writes of 0; gmax=0, gmax_bin=16; donemag at cycle 3586.
- **Single bin, negative imag:** bin 40 has re=0x0001_0000 (1.0) and im=0x8002_0000 (−2.0), all others 0 → Fw[40]=0x0005_0000; gmax=0x0005_0000, gmax_bin=40.
- **Peak outside range:** bin 200 re=10.0 and bin 50 re=1.0 → Fw[200]=0x0064_0000 written; gmax=0x0001_0000, gmax_bin=50.
- **Range edges and ties:**
  - Bins 15 (re=3.0) and 128 (re=2.0) → gmax_bin=128, gmax=0x0004_0000.
  - Separate run with bins 30 and 90 both re=2.0 → gmax_bin=30.
- **Saturation:** bin 20 re=0x7FFF_0000, im=0x0001_0000 → Fw[20]=0x7FFF_FFFF; gmax=0x7FFF_FFFF, gmax_bin=20.
- **Control:**
  - startmag held high throughout → exactly one run, then a second run starts from IDLE.
  - rst=0 at bin 100 → all outputs at reset values the next cycle and no donemag.
  - A fresh start after rst runs correctly.
